// File: rtl/dac_sweep_pkg.sv
// Shared types and default widths for the DAC frequency-sweep sequencer.
package dac_sweep_pkg;

  localparam int STEP_W  = 32;
  localparam int DWELL_W = 32;
  localparam int PTS_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dac_sweep_dwell_timer.sv
// Dwell down-counter: load with max(value,1), count down while enabled, flag the last cycle.
module dac_sweep_dwell_timer #(
  parameter int DWELL_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               enable_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
    end else if (enable_i && cnt_q > DWELL_W'(1)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/dac_sweep_ctrl.sv
// Linear DDS phase-step sweep sequencer with busy/done status.
// Define DAC_SWEEP_PINGPONG_EN for triangular (up/down) looped sweeps instead of sawtooth.
module dac_sweep_ctrl #(
  parameter int STEP_W  = dac_sweep_pkg::STEP_W,
  parameter int DWELL_W = dac_sweep_pkg::DWELL_W,
  parameter int PTS_W   = dac_sweep_pkg::PTS_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [STEP_W-1:0]  cfg_start_step,
  input  logic [STEP_W-1:0]  cfg_delta_step,
  input  logic [PTS_W-1:0]   cfg_num_points,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  output logic [STEP_W-1:0]  dds_step,
  output logic               dds_step_valid,
  output logic [PTS_W-1:0]   point_idx,
  output logic               busy,
  output logic               done
);

  import dac_sweep_pkg::*;

  sweep_state_t       state_q;
  logic [STEP_W-1:0]  step_q, start_step_q, delta_q;
  logic [PTS_W-1:0]   idx_q, last_idx_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q, down_q;
  logic               valid_q, busy_q, done_q;

  logic               start_go, run, expire, tmr_load;
  logic [DWELL_W-1:0] tmr_val;

  // stop outranks start, so a simultaneous start is simply dropped
  assign start_go = start & ~stop;
  assign run      = (state_q == RUN);
  assign tmr_load = start_go | (run & expire);
  assign tmr_val  = start_go ? cfg_dwell : dwell_q;

  dac_sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .enable_i   (run),
    .load_val_i (tmr_val),
    .expire_o   (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the config shadows are reset along with the datapath so no flop is X after reset.
      state_q      <= IDLE;
      step_q       <= '0;
      idx_q        <= '0;
      start_step_q <= '0;
      delta_q      <= '0;
      last_idx_q   <= '0;
      dwell_q      <= '0;
      loop_q       <= 1'b0;
      down_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; only the branches below raise them for one cycle.
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (start) begin
        start_step_q <= cfg_start_step;
        delta_q      <= cfg_delta_step;
        last_idx_q   <= (cfg_num_points == '0) ? '0 : cfg_num_points - PTS_W'(1);
        dwell_q      <= cfg_dwell;
        loop_q       <= cfg_loop;
        down_q       <= 1'b0;
        step_q       <= cfg_start_step;
        idx_q        <= '0;
        valid_q      <= 1'b1;
        busy_q       <= 1'b1;
        state_q      <= RUN;
      end else begin
        unique case (state_q)
          RUN: begin
            if (expire) begin
              if (!down_q && idx_q != last_idx_q) begin
                step_q  <= step_q + delta_q;
                idx_q   <= idx_q + PTS_W'(1);
                valid_q <= 1'b1;
              end else if (!loop_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
`ifdef DAC_SWEEP_PINGPONG_EN
                // Reverse at either endpoint; a single-point sweep just re-strobes the same step.
                valid_q <= 1'b1;
                if (!down_q) begin
                  if (last_idx_q != '0) begin
                    down_q <= 1'b1;
                    step_q <= step_q - delta_q;
                    idx_q  <= idx_q - PTS_W'(1);
                  end
                end else if (idx_q == '0) begin
                  down_q <= 1'b0;
                  step_q <= step_q + delta_q;
                  idx_q  <= idx_q + PTS_W'(1);
                end else begin
                  step_q <= step_q - delta_q;
                  idx_q  <= idx_q - PTS_W'(1);
                end
`else
                step_q  <= start_step_q;
                idx_q   <= '0;
                valid_q <= 1'b1;
`endif
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dds_step       = step_q;
  assign dds_step_valid = valid_q;
  assign point_idx      = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Self-checking bench for dac_sweep_ctrl: directed vector table, corner sequences, random sweeps.
module tb_dac_sweep_ctrl;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] delta;
    logic [15:0] n;
    logic [31:0] dwell;
    logic        loop;
  } cfg_t;

  typedef struct packed {
    logic [31:0] step;
    logic [15:0] idx;
    logic        valid;
    logic        busy;
    logic        done;
  } out_t;

  typedef struct {
    string name;
    cfg_t  c;
    int    k;
    out_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, cfg_loop;
  logic [31:0] cfg_start_step, cfg_delta_step, cfg_dwell;
  logic [15:0] cfg_num_points;
  logic [31:0] dds_step;
  logic [15:0] point_idx;
  logic        dds_step_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dac_sweep_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .cfg_start_step (cfg_start_step),
    .cfg_delta_step (cfg_delta_step),
    .cfg_num_points (cfg_num_points),
    .cfg_dwell      (cfg_dwell),
    .cfg_loop       (cfg_loop),
    .dds_step       (dds_step),
    .dds_step_valid (dds_step_valid),
    .point_idx      (point_idx),
    .busy           (busy),
    .done           (done)
  );

  function automatic cfg_t mk(logic [31:0] s, logic [31:0] d, logic [15:0] n,
                              logic [31:0] dw, logic lp);
    cfg_t c;
    c.start = s; c.delta = d; c.n = n; c.dwell = dw; c.loop = lp;
    return c;
  endfunction

  function automatic out_t mo(logic [31:0] s, logic [15:0] i, logic v, logic b, logic d);
    out_t o;
    o.step = s; o.idx = i; o.valid = v; o.busy = b; o.done = d;
    return o;
  endfunction

  // Expected outputs k cycles after the start edge (k = 0 is the first strobed point).
  function automatic out_t model(cfg_t c, int k);
    int   n, d, p, pos;
    out_t o;
    n = (c.n == 0) ? 1 : int'(c.n);
    d = (c.dwell == 0) ? 1 : int'(c.dwell);
    p = k / d;
    o.valid = (k % d == 0);
    o.busy  = 1'b1;
    o.done  = 1'b0;
    if (!c.loop) begin
      if (p >= n) begin
        pos = n - 1; o.valid = 1'b0; o.busy = 1'b0; o.done = (k == n * d);
      end else begin
        pos = p;
      end
    end else begin
`ifdef DAC_SWEEP_PINGPONG_EN
      if (n == 1) pos = 0;
      else begin
        int per, q;
        per = 2 * n - 2;
        q   = p % per;
        pos = (q < n) ? q : per - q;
      end
`else
      pos = p % n;
`endif
    end
    o.idx  = 16'(pos);
    o.step = c.start + c.delta * 32'(pos);
    return o;
  endfunction

  function automatic out_t sample();
    return mo(dds_step, point_idx, dds_step_valid, busy, done);
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got step=%h idx=%0d valid=%b busy=%b done=%b, want step=%h idx=%0d valid=%b busy=%b done=%b",
               name, act.step, act.idx, act.valid, act.busy, act.done,
               exp.step, exp.idx, exp.valid, exp.busy, exp.done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with c, then scramble cfg_* so later config changes must be ignored.
  task automatic do_start(cfg_t c);
    cfg_start_step = c.start;
    cfg_delta_step = c.delta;
    cfg_num_points = c.n;
    cfg_dwell      = c.dwell;
    cfg_loop       = c.loop;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_start_step = $urandom;
    cfg_delta_step = $urandom;
    cfg_num_points = 16'($urandom);
    cfg_dwell      = $urandom_range(0, 7);
    cfg_loop       = 1'($urandom);
  endtask

  vec_t vecs[$];

  initial begin
    cfg_t c, c2;
    out_t held;

    // Directed vectors; step/idx/valid/busy/done worked out by hand.
    vecs.push_back('{"t1_k0",  mk(100, 10, 4, 3, 0), 0,  mo(100, 0, 1, 1, 0)});
    vecs.push_back('{"t1_k2",  mk(100, 10, 4, 3, 0), 2,  mo(100, 0, 0, 1, 0)});
    vecs.push_back('{"t1_k3",  mk(100, 10, 4, 3, 0), 3,  mo(110, 1, 1, 1, 0)});
    vecs.push_back('{"t1_k9",  mk(100, 10, 4, 3, 0), 9,  mo(130, 3, 1, 1, 0)});
    vecs.push_back('{"t1_k11", mk(100, 10, 4, 3, 0), 11, mo(130, 3, 0, 1, 0)});
    vecs.push_back('{"t1_done",mk(100, 10, 4, 3, 0), 12, mo(130, 3, 0, 0, 1)});
    vecs.push_back('{"t1_idle",mk(100, 10, 4, 3, 0), 13, mo(130, 3, 0, 0, 0)});
    vecs.push_back('{"dw0_k1", mk(100, 10, 4, 0, 0), 1,  mo(110, 1, 1, 1, 0)});
    vecs.push_back('{"dw0_k3", mk(100, 10, 4, 0, 0), 3,  mo(130, 3, 1, 1, 0)});
    vecs.push_back('{"dw0_done",mk(100, 10, 4, 0, 0), 4, mo(130, 3, 0, 0, 1)});
    vecs.push_back('{"dw1_k3", mk(100, 10, 4, 1, 0), 3,  mo(130, 3, 1, 1, 0)});
    vecs.push_back('{"wrap",   mk(32'hFFFF_FFF0, 32'h20, 2, 1, 0), 1, mo(32'h10, 1, 1, 1, 0)});
    vecs.push_back('{"neg_k4", mk(20, 32'hFFFF_FFFB, 3, 2, 0), 4, mo(10, 2, 1, 1, 0)});
    vecs.push_back('{"n0_done",mk(77, 5, 0, 2, 0), 2,   mo(77, 0, 0, 0, 1)});
`ifdef DAC_SWEEP_PINGPONG_EN
    vecs.push_back('{"loop_k6", mk(0, 1, 3, 2, 1), 6,  mo(1, 1, 1, 1, 0)});
    vecs.push_back('{"loop_k8", mk(0, 1, 3, 2, 1), 8,  mo(0, 0, 1, 1, 0)});
`else
    vecs.push_back('{"loop_k6", mk(0, 1, 3, 2, 1), 6,  mo(0, 0, 1, 1, 0)});
    vecs.push_back('{"loop_k8", mk(0, 1, 3, 2, 1), 8,  mo(1, 1, 1, 1, 0)});
`endif
    vecs.push_back('{"loop_k9", mk(0, 1, 3, 2, 1), 9,  mo(model(mk(0, 1, 3, 2, 1), 9).step,
                                                         model(mk(0, 1, 3, 2, 1), 9).idx, 0, 1, 0)});

    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_start_step = '0; cfg_delta_step = '0; cfg_num_points = '0; cfg_dwell = '0; cfg_loop = 1'b0;
    tick(); tick();
    check("reset", sample(), mo(0, 0, 0, 0, 0));
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", sample(), mo(0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      do_start(vecs[i].c);
      repeat (vecs[i].k) tick();
      check(vecs[i].name, sample(), vecs[i].exp);
    end

    // Restart mid-sweep: new start value takes over, aborted pass issues no done.
    c = mk(100, 10, 4, 3, 0);
    do_start(c);
    repeat (4) tick();
    check("pre_restart", sample(), model(c, 4));
    c2 = mk(500, 10, 4, 3, 0);
    do_start(c2);
    check("restart_k0", sample(), mo(500, 0, 1, 1, 0));
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("restart_k%0d", k), sample(), model(c2, k));
    end

    // start and stop together while IDLE: start is dropped.
    cfg_start_step = 999; cfg_num_points = 2; cfg_dwell = 1; cfg_loop = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", sample(), mo(530, 3, 0, 0, 0));
    tick();
    check("start_stop_idle2", sample(), mo(530, 3, 0, 0, 0));

    // stop in a looped sweep: outputs hold, no strobe, no done.
    c = mk(0, 1, 3, 2, 1);
    do_start(c);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("loop_run_k%0d", k), sample(), model(c, k));
    end
    held = model(c, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("loop_stop_%0d", k), sample(), mo(held.step, held.idx, 0, 0, 0));
      tick();
    end

    // Reset mid-sweep clears everything at the next edge.
    c = mk(32'h1234, 3, 5, 2, 1);
    do_start(c);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("reset_mid", sample(), mo(0, 0, 0, 0, 0));
    reset_n = 1'b1;
    tick();
    check("reset_mid_idle", sample(), mo(0, 0, 0, 0, 0));

    // Random sweeps against the reference model.
    for (int it = 0; it < 40; it++) begin
      int n_eff, d_eff, len, s;
      c = mk($urandom, $urandom, 16'($urandom_range(0, 5)), $urandom_range(0, 4),
             1'($urandom_range(0, 1)));
      n_eff = (c.n == 0) ? 1 : int'(c.n);
      d_eff = (c.dwell == 0) ? 1 : int'(c.dwell);
      do_start(c);
      check($sformatf("rnd%0d_k0", it), sample(), model(c, 0));
      if (!c.loop) begin
        len = n_eff * d_eff + 2;
        for (int k = 1; k <= len; k++) begin
          tick();
          check($sformatf("rnd%0d_k%0d", it, k), sample(), model(c, k));
        end
      end else begin
        s = $urandom_range(1, 3 * n_eff * d_eff + 2);
        for (int k = 1; k <= s; k++) begin
          tick();
          check($sformatf("rnd%0d_k%0d", it, k), sample(), model(c, k));
        end
        held = model(c, s);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check($sformatf("rnd%0d_stop", it), sample(), mo(held.step, held.idx, 0, 0, 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
